// File: rtl/matvec_mac_array.sv
// LANES-wide signed multiply-accumulate array. Each lane accumulates a dot product over a vector
// of cfg_len+1 beats and presents one saturated or wrapped pre-activation sum per lane.
module matvec_mac_array #(
    parameter int DATA_W   = 16,
    parameter int DROP_LSB = 3,
    parameter int LANES    = 4,
    parameter int ACC_W    = 24,
    parameter int LEN_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [LEN_W-1:0]         i_cfg_len,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [LANES*DATA_W-1:0]  i_weight,
    input  logic [LANES*DATA_W-1:0]  i_xt,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [LANES*ACC_W-1:0]   o_ai,
    output logic [LANES-1:0]         o_overflow,
    output logic                     o_busy
);

    localparam int OP_W   = DATA_W - DROP_LSB;
    localparam int PROD_W = 2 * OP_W;
    // A full-scale product can exceed ACC_W, so the sum is sized to whichever of the two is wider.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_beat;
    logic [LEN_W-1:0]   w_beat_next;
    logic [1:0]         r_drain_cnt;
    logic               r_s1_valid;
    logic               r_s2_valid;
    logic               w_accept;
    logic               w_vec_start;
    logic               w_load_out;

    // Reset gating keeps the input closed while reset is held, so reset always wins a handshake.
    assign o_in_ready  = ~i_reset & ((r_state == ST_IDLE) || (r_state == ST_ACCUM));
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_vec_start = w_accept & (r_state == ST_IDLE);
    assign w_beat_next = r_beat + LEN_W'(1);
    assign w_load_out  = (r_state == ST_DRAIN) && (r_drain_cnt == 2'd2);
    assign o_out_valid = (r_state == ST_OUTPUT);
    assign o_busy      = (r_state != ST_IDLE);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (i_cfg_len == '0) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (w_accept && (w_beat_next == r_len)) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == 2'd2) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (i_out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // r_beat holds the index of the most recently accepted beat of the current vector.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_len       <= '0;
            r_beat      <= '0;
            r_drain_cnt <= 2'd0;
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            if (w_vec_start) begin
                r_len  <= i_cfg_len;
                r_beat <= '0;
            end else if (w_accept) begin
                r_beat <= w_beat_next;
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? (r_drain_cnt + 2'd1) : 2'd0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [OP_W-1:0]   r_op_w;
            logic signed [OP_W-1:0]   r_op_x;
            logic signed [PROD_W-1:0] r_prod;
            logic signed [ACC_W-1:0]  r_acc;
            logic                     r_ovf;
            logic [ACC_W-1:0]         r_ai;
            logic                     r_ovf_out;
            logic signed [SUM_W-1:0]  w_sum;
            logic [SUM_W-ACC_W:0]     w_top;
            logic                     w_ovf;
            logic [ACC_W-1:0]         w_acc_next;
            logic                     w_unused_lsbs;

            assign w_unused_lsbs = ^{i_weight[gi*DATA_W +: DROP_LSB], i_xt[gi*DATA_W +: DROP_LSB]};

            // Taking the upper OP_W bits is the arithmetic right shift by DROP_LSB.
            always_ff @(posedge i_clock) begin
                r_op_w <= i_weight[gi*DATA_W+DROP_LSB +: OP_W];
                r_op_x <= i_xt[gi*DATA_W+DROP_LSB +: OP_W];
                r_prod <= PROD_W'(r_op_w) * PROD_W'(r_op_x);
            end

            assign w_sum = SUM_W'(r_acc) + SUM_W'(r_prod);
            assign w_top = w_sum[SUM_W-1:ACC_W-1];
            // In range only when every bit above the ACC_W sign bit matches it.
            assign w_ovf = ~((&w_top) | ~(|w_top));

            if (SATURATE != 0) begin : g_sat
                assign w_acc_next = w_ovf ? (w_sum[SUM_W-1] ? ACC_MIN : ACC_MAX)
                                          : w_sum[ACC_W-1:0];
            end else begin : g_wrap
                assign w_acc_next = w_sum[ACC_W-1:0];
            end

            always_ff @(posedge i_clock) begin
                if (i_reset || w_vec_start) begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                end else if (r_s2_valid) begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_ovf;
                end
            end

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_ai      <= '0;
                    r_ovf_out <= 1'b0;
                end else if (w_load_out) begin
                    r_ai      <= r_acc;
                    r_ovf_out <= r_ovf;
                end
            end

            assign o_ai[gi*ACC_W +: ACC_W] = r_ai;
            assign o_overflow[gi]          = r_ovf_out;
        end
    endgenerate

endmodule

// File: tb/tb_matvec_mac_array.sv
// Directed bench for matvec_mac_array: a saturating and a wrapping instance share all stimulus,
// and a scoreboard of model results is checked at each output handshake.
module tb_matvec_mac_array;

    localparam int DATA_W   = 16;
    localparam int DROP_LSB = 3;
    localparam int LANES    = 4;
    localparam int ACC_W    = 24;
    localparam int LEN_W    = 8;
    localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

    typedef struct {
        logic [LANES*ACC_W-1:0] ai_s;
        logic [LANES*ACC_W-1:0] ai_w;
        logic [LANES-1:0]       ov_s;
        logic [LANES-1:0]       ov_w;
    } exp_t;

    logic                    i_clock = 1'b0;
    logic                    i_reset;
    logic [LEN_W-1:0]        i_cfg_len;
    logic                    i_in_valid;
    logic [LANES*DATA_W-1:0] i_weight;
    logic [LANES*DATA_W-1:0] i_xt;
    logic                    i_out_ready;
    logic                    o_in_ready,  o_in_ready_w;
    logic                    o_out_valid, o_out_valid_w;
    logic [LANES*ACC_W-1:0]  o_ai,        o_ai_w;
    logic [LANES-1:0]        o_overflow,  o_overflow_w;
    logic                    o_busy,      o_busy_w;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];
    logic [LANES*DATA_W-1:0] vw[$];
    logic [LANES*DATA_W-1:0] vx[$];

    always #5 i_clock = ~i_clock;

    matvec_mac_array #(.DATA_W(DATA_W), .DROP_LSB(DROP_LSB), .LANES(LANES), .ACC_W(ACC_W),
                       .LEN_W(LEN_W), .SATURATE(1)) dut_sat (
        .i_clock(i_clock), .i_reset(i_reset), .i_cfg_len(i_cfg_len), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .i_weight(i_weight), .i_xt(i_xt), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_ai(o_ai), .o_overflow(o_overflow), .o_busy(o_busy));

    matvec_mac_array #(.DATA_W(DATA_W), .DROP_LSB(DROP_LSB), .LANES(LANES), .ACC_W(ACC_W),
                       .LEN_W(LEN_W), .SATURATE(0)) dut_wrap (
        .i_clock(i_clock), .i_reset(i_reset), .i_cfg_len(i_cfg_len), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready_w), .i_weight(i_weight), .i_xt(i_xt), .o_out_valid(o_out_valid_w),
        .i_out_ready(i_out_ready), .o_ai(o_ai_w), .o_overflow(o_overflow_w), .o_busy(o_busy_w));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Reference: per-lane accumulation in wide integers, clamped or wrapped after every term.
    task automatic push_expected();
        exp_t e;
        for (int l = 0; l < LANES; l++) begin
            longint acc_s = 0;
            longint acc_w = 0;
            logic os = 1'b0;
            logic ow = 1'b0;
            for (int b = 0; b < vw.size(); b++) begin
                logic signed [DATA_W-1:0] ws;
                logic signed [DATA_W-1:0] xs;
                longint prod, s;
                ws = vw[b][l*DATA_W +: DATA_W];
                xs = vx[b][l*DATA_W +: DATA_W];
                prod = longint'(ws >>> DROP_LSB) * longint'(xs >>> DROP_LSB);
                s = acc_s + prod;
                if (s > AMAX) begin os = 1'b1; acc_s = AMAX; end
                else if (s < AMIN) begin os = 1'b1; acc_s = AMIN; end
                else acc_s = s;
                s = acc_w + prod;
                if (s > AMAX || s < AMIN) ow = 1'b1;
                s = s & ((64'sd1 <<< ACC_W) - 1);
                if (s > AMAX) s = s - (64'sd1 <<< ACC_W);
                acc_w = s;
            end
            e.ai_s[l*ACC_W +: ACC_W] = acc_s[ACC_W-1:0];
            e.ai_w[l*ACC_W +: ACC_W] = acc_w[ACC_W-1:0];
            e.ov_s[l] = os;
            e.ov_w[l] = ow;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_beat(input logic [LANES*DATA_W-1:0] w, input logic [LANES*DATA_W-1:0] x);
        logic acc;
        int n;
        i_in_valid = 1'b1;
        i_weight   = w;
        i_xt       = x;
        n = 0;
        do begin
            acc = o_in_ready;
            tick();
            n++;
        end while (!acc && n < 500);
        check("beat_accept", acc, 1'b1);
    endtask

    // Drives the vector held in vw/vx with optional idle cycles between beats.
    task automatic run_vector(input int gap);
        push_expected();
        i_cfg_len = LEN_W'(vw.size() - 1);
        for (int b = 0; b < vw.size(); b++) begin
            drive_beat(vw[b], vx[b]);
            i_cfg_len = LEN_W'($urandom);
            if (gap > 0 && b < vw.size() - 1) begin
                i_in_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    check("ready_in_gap", o_in_ready, 1'b1);
                    tick();
                end
            end
        end
        i_in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!o_out_valid && n < 100) begin
            tick();
            n++;
        end
        check("latency", n, 3);
    endtask

    task automatic collect(input int hold, input bit drop_valid);
        exp_t e;
        check("queue_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        i_out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", o_out_valid, 1'b1);
            check("hold_ai", o_ai, e.ai_s);
            check("hold_in_ready", o_in_ready, 1'b0);
            tick();
        end
        if (drop_valid) i_in_valid = 1'b0;
        check("out_valid", o_out_valid, 1'b1);
        check("ai_sat", o_ai, e.ai_s);
        check("ovf_sat", o_overflow, e.ov_s);
        check("out_valid_wrap", o_out_valid_w, 1'b1);
        check("ai_wrap", o_ai_w, e.ai_w);
        check("ovf_wrap", o_overflow_w, e.ov_w);
        $display("result ai_sat=%h ovf_sat=%b ai_wrap=%h ovf_wrap=%b", o_ai, o_overflow, o_ai_w, o_overflow_w);
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        check("valid_drop", o_out_valid, 1'b0);
        check("ready_after", o_in_ready, 1'b1);
        check("idle_after", o_busy, 1'b0);
        check("ai_retained", o_ai, e.ai_s);
    endtask

    function automatic logic [LANES*DATA_W-1:0] splat(input logic [DATA_W-1:0] v);
        return {LANES{v}};
    endfunction

    initial begin
        i_reset = 1'b1; i_cfg_len = '0; i_in_valid = 1'b0;
        i_weight = '0; i_xt = '0; i_out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", o_out_valid, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_in_ready", o_in_ready, 1'b0);
        check("rst_ai", o_ai, '0);
        check("rst_ovf", o_overflow, '0);
        i_reset = 1'b0;
        #1;
        check("ready_after_reset", o_in_ready, 1'b1);

        // T1: 4 beats of 10*3 per lane
        vw = {}; vx = {};
        for (int b = 0; b < 4; b++) begin vw.push_back(splat(16'd80)); vx.push_back(splat(16'd24)); end
        run_vector(0);
        wait_result();
        collect(0, 1'b1);

        // T2: lane0 (-1)*2 twice with a 2-cycle valid gap
        vw = {}; vx = {};
        for (int b = 0; b < 2; b++) begin vw.push_back(64'h0000_0000_0000_FFF8); vx.push_back(64'h0000_0000_0000_0010); end
        run_vector(2);
        wait_result();
        collect(0, 1'b1);

        // T3: full-scale products both polarities, single beat
        vw = {}; vx = {};
        vw.push_back({16'hFFF8, 16'h0050, 16'h8000, 16'h8000});
        vx.push_back({16'h0018, 16'h0018, 16'h7FF8, 16'h8000});
        run_vector(0);
        wait_result();
        collect(0, 1'b1);

        // Accumulation continues from the clamped value
        vw = {}; vx = {};
        vw.push_back(splat(16'h8000)); vx.push_back(splat(16'h8000));
        vw.push_back(splat(16'h8000)); vx.push_back(splat(16'h7FF8));
        vw.push_back(splat(16'h0050)); vx.push_back(splat(16'h0018));
        run_vector(1);
        wait_result();
        collect(0, 1'b1);

        // T4: 10 cycles of output backpressure with new beats offered
        vw = {}; vx = {};
        for (int b = 0; b < 3; b++) begin vw.push_back(splat(16'h0123 + 16'(b))); vx.push_back(splat(16'hFF00)); end
        run_vector(0);
        wait_result();
        i_in_valid = 1'b1; i_weight = splat(16'h7FF8); i_xt = splat(16'h7FF8); i_cfg_len = 8'd0;
        collect(10, 1'b1);

        // T5: reset after beat 2 of a 6-beat vector
        i_cfg_len = 8'd5;
        drive_beat(splat(16'h4000), splat(16'h4000));
        drive_beat(splat(16'h4000), splat(16'h4000));
        i_in_valid = 1'b0;
        i_reset = 1'b1;
        tick();
        check("mid_rst_out_valid", o_out_valid, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        check("mid_rst_in_ready", o_in_ready, 1'b0);
        check("mid_rst_ai", o_ai, '0);
        check("mid_rst_ai_wrap", o_ai_w, '0);
        i_reset = 1'b0;
        #1;
        vw = {}; vx = {};
        vw.push_back(splat(16'd80)); vx.push_back(splat(16'd24));
        run_vector(0);
        wait_result();
        collect(0, 1'b1);

        // T6: next vector's first beat held valid through DRAIN and OUTPUT
        vw = {}; vx = {};
        for (int b = 0; b < 2; b++) begin vw.push_back({16'h0100, 16'hFF00, 16'h0040, 16'h1000}); vx.push_back(splat(16'h0200)); end
        run_vector(0);
        i_in_valid = 1'b1; i_cfg_len = 8'd1;
        i_weight = splat(16'h0088); i_xt = splat(16'hFFC0);
        wait_result();
        collect(2, 1'b0);
        vw = {}; vx = {};
        vw.push_back(splat(16'h0088)); vx.push_back(splat(16'hFFC0));
        vw.push_back(splat(16'h0030)); vx.push_back(splat(16'h0070));
        run_vector(0);
        wait_result();
        collect(0, 1'b1);

        // Full-range random vector, then a small-range one that stays in range
        vw = {}; vx = {};
        for (int b = 0; b < 8; b++) begin vw.push_back({$urandom, $urandom}); vx.push_back({$urandom, $urandom}); end
        run_vector(0);
        wait_result();
        collect(1, 1'b1);
        vw = {}; vx = {};
        for (int b = 0; b < 16; b++) begin
            logic [LANES*DATA_W-1:0] w, x;
            for (int l = 0; l < LANES; l++) begin
                w[l*DATA_W +: DATA_W] = 16'($urandom_range(0, 1600)) - 16'd800;
                x[l*DATA_W +: DATA_W] = 16'($urandom_range(0, 1600)) - 16'd800;
            end
            vw.push_back(w); vx.push_back(x);
        end
        run_vector(1);
        wait_result();
        collect(0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
